// File: rtl/mips_regfile_sched.sv
// mips_regfile_sched: shares a one-operation-per-cycle MIPS register file
// between decode-stage reads and buffered writeback-stage writes. Reads are
// ordered against buffered writes and register 0 always reads as zero.
module mips_regfile_sched #(
  parameter int WBUF_DEPTH     = 2,
  parameter int WRITE_WAIT_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_reg,
  input  logic [31:0] wr_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [4:0]  rd_reg_1,
  input  logic [4:0]  rd_reg_2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data_1,
  output logic [31:0] rsp_data_2,
  output logic        rf_signal_reg_write,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic [4:0]  rf_read_reg_1,
  output logic [4:0]  rf_read_reg_2,
  input  logic [31:0] rf_read_data_1,
  input  logic [31:0] rf_read_data_2
);
  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW = $clog2(WRITE_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(WRITE_WAIT_MAX);

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_ISSUED = 2'd1,
    R_HOLD   = 2'd2
  } rstate_e;

  logic [4:0]            buf_reg_q  [WBUF_DEPTH];
  logic [31:0]           buf_data_q [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         wait_q, wait_d;
  rstate_e               state_q, state_d;
  logic [4:0]            idx1_q, idx1_d, idx2_q, idx2_d;
  logic [31:0]           rsp1_q, rsp1_d, rsp2_q, rsp2_d;

  logic full, empty, hazard, read_ok, read_grant, write_grant, push;

  // Arbitration: the pending read wins unless it is hazarded, the buffer is
  // full, or the buffered head has already been bypassed too long.
  always_comb begin
    full   = &vld_q;
    empty  = ~|vld_q;
    hazard = 1'b0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (vld_q[i] && (buf_reg_q[i] != 5'd0) &&
          (((rd_reg_1 != 5'd0) && (buf_reg_q[i] == rd_reg_1)) ||
           ((rd_reg_2 != 5'd0) && (buf_reg_q[i] == rd_reg_2))))
        hazard = 1'b1;
    end
    read_ok     = rd_valid && !hazard &&
                  ((state_q == R_IDLE) || ((state_q == R_HOLD) && rsp_ready));
    read_grant  = read_ok && !full && (wait_q < WAIT_MAX);
    write_grant = !empty && !read_grant;
    rd_ready    = read_grant;
    wr_ready    = !full || write_grant;
    push        = wr_valid && wr_ready && (wr_reg != 5'd0);
  end

  // Next-state for the write buffer, bypass counter, read FSM and captures.
  always_comb begin
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    wait_d  = wait_q;
    state_d = state_q;
    idx1_d  = idx1_q;
    idx2_d  = idx2_q;
    rsp1_d  = rsp1_q;
    rsp2_d  = rsp2_q;
    // Pop is applied before push so a full buffer can pop and push at once.
    if (write_grant) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PW'(1);
    end
    if (empty || write_grant)  wait_d = '0;
    else if (wait_q < WAIT_MAX) wait_d = wait_q + CW'(1);
    if (read_grant) begin
      idx1_d = rd_reg_1;
      idx2_d = rd_reg_2;
    end
    unique case (state_q)
      R_IDLE:   if (read_grant) state_d = R_ISSUED;
      R_ISSUED: begin
        state_d = R_HOLD;
        rsp1_d  = (idx1_q == 5'd0) ? 32'd0 : rf_read_data_1;
        rsp2_d  = (idx2_q == 5'd0) ? 32'd0 : rf_read_data_2;
      end
      R_HOLD:   if (rsp_ready) state_d = read_grant ? R_ISSUED : R_IDLE;
      default:  state_d = R_IDLE;
    endcase
  end

  // Register-file port drive; read addresses hold the last issued indices.
  always_comb begin
    rf_signal_reg_write = write_grant;
    rf_write_reg        = write_grant ? buf_reg_q[head_q]  : 5'd0;
    rf_write_data       = write_grant ? buf_data_q[head_q] : 32'd0;
    rf_read_reg_1       = read_grant ? rd_reg_1 : idx1_q;
    rf_read_reg_2       = read_grant ? rd_reg_2 : idx2_q;
    rsp_valid           = (state_q == R_HOLD);
    rsp_data_1          = rsp1_q;
    rsp_data_2          = rsp2_q;
  end

  // Control and response state, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      wait_q  <= '0;
      state_q <= R_IDLE;
      idx1_q  <= 5'd0;
      idx2_q  <= 5'd0;
      rsp1_q  <= 32'd0;
      rsp2_q  <= 32'd0;
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      wait_q  <= wait_d;
      state_q <= state_d;
      idx1_q  <= idx1_d;
      idx2_q  <= idx2_d;
      rsp1_q  <= rsp1_d;
      rsp2_q  <= rsp2_d;
    end
  end

  // Write-buffer storage; entries are qualified by vld_q so need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_reg_q[tail_q]  <= wr_reg;
      buf_data_q[tail_q] <= wr_data;
    end
  end
endmodule
